// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, status codes and the memory-access FSM states.
package y86_pkg;

    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'b000;
    localparam logic [2:0] STAT_INS = 3'b001;
    localparam logic [2:0] STAT_ADR = 3'b010;
    localparam logic [2:0] STAT_HLT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_op_classify.sv
// Combinational decode of icode + incoming status into memory direction, address source and status.
module mem_op_classify
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [2:0] stat,
    output logic       is_read,
    output logic       is_write,
    output logic       addr_sel,
    output logic [2:0] pass_stat
);

    always_comb begin
        is_read   = 1'b0;
        is_write  = 1'b0;
        addr_sel  = 1'b0;
        pass_stat = stat;

        if (stat[1]) begin
            pass_stat = STAT_ADR;
        end else if (stat[0]) begin
            pass_stat = STAT_INS;
        end else if (icode == HALT) begin
            pass_stat = STAT_HLT;
        end

        // A faulted or halting instruction never touches memory.
        if (pass_stat == STAT_AOK) begin
            case (icode)
                RMMOV, CALL, PUSH: is_write = 1'b1;
                MRMOV:             is_read  = 1'b1;
                RET, POP: begin
                    is_read  = 1'b1;
                    addr_sel = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_initiator.sv
// Memory-stage request side: classifies an execute result, runs one req/ack beat, reports to writeback.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_initiator
    import y86_pkg::*;
#(
    parameter int MEM_DEPTH      = 4096,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [3:0]        e_Ins_Code,
    input  logic [3:0]        e_Ins_fun,
    input  logic [63:0]       e_Value_E,
    input  logic [63:0]       e_value_A,
    input  logic [2:0]        e_stat,
    input  logic [63:0]       f_no_of_valid_instruction,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_err,
    output logic              m_valid,
    output logic [3:0]        m_Ins_Code,
    output logic [63:0]       m_Value_E,
    output logic [63:0]       m_Value_M,
    output logic [2:0]        m_stat,
    output logic              halted
);

    localparam logic [63:0] MAX_ADDR = 64'(MEM_DEPTH - 1);

    mem_state_t  state_q, state_d;
    logic        is_read, is_write, addr_sel;
    logic [2:0]  pass_stat;
    logic        accept, mem_op, addr_bad, go_req;
    logic [63:0] req_addr;
    logic [2:0]  accept_stat, ack_stat;
    logic        op_read_q;
    logic        ack_done, timeout_hit;

    // ifun has no consumer on the memory-request side.
    logic unused_ifun;
    assign unused_ifun = ^e_Ins_fun;

    mem_op_classify u_classify (
        .icode     (e_Ins_Code),
        .stat      (e_stat),
        .is_read   (is_read),
        .is_write  (is_write),
        .addr_sel  (addr_sel),
        .pass_stat (pass_stat)
    );

    assign mem_req  = (state_q == REQ);
    assign m_valid  = (state_q == RESP);
    assign ack_done = (state_q == REQ) && mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || state_q != REQ) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state_q == REQ) && !mem_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        e_ready     = !halted && (state_q == IDLE || state_q == RESP);
        accept      = e_valid && e_ready;
        req_addr    = addr_sel ? e_value_A : e_Value_E;
        mem_op      = is_read || is_write;
        addr_bad    = mem_op && (req_addr > MAX_ADDR);
        go_req      = accept && mem_op && !addr_bad;
        accept_stat = addr_bad ? STAT_ADR : pass_stat;

        ack_stat = STAT_AOK;
        if (mem_err) begin
            ack_stat = STAT_ADR;
        end else if (m_Ins_Code == RET && op_read_q && mem_rdata > f_no_of_valid_instruction) begin
            ack_stat = STAT_INS;
        end

        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = go_req ? REQ : RESP;
                end
            end
            REQ: begin
                if (ack_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage boundary: execute result captured on accept, memory result captured on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m_Ins_Code <= NOP;
            m_Value_E  <= '0;
            m_Value_M  <= '0;
            m_stat     <= STAT_AOK;
            halted     <= 1'b0;
            op_read_q  <= 1'b0;
        end else if (accept) begin
            m_Ins_Code <= e_Ins_Code;
            m_Value_E  <= e_Value_E;
            m_Value_M  <= '0;
            m_stat     <= accept_stat;
            if (go_req) begin
                mem_addr  <= req_addr[ADDR_W-1:0];
                mem_we    <= is_write;
                mem_wdata <= is_write ? e_value_A : '0;
                op_read_q <= is_read;
            end else if (accept_stat != STAT_AOK) begin
                halted <= 1'b1;
            end
        end else if (ack_done) begin
            m_stat    <= ack_stat;
            m_Value_M <= (!mem_err && op_read_q) ? mem_rdata : '0;
            if (ack_stat != STAT_AOK) begin
                halted <= 1'b1;
            end
        end else if (timeout_hit) begin
            m_stat    <= STAT_ADR;
            m_Value_M <= '0;
            halted    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed self-checking bench for mem_access_initiator; inputs driven and outputs sampled 1ns after posedge.
module tb_mem_access_initiator;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic        e_ready;
    logic [3:0]  e_Ins_Code;
    logic [3:0]  e_Ins_fun;
    logic [63:0] e_Value_E;
    logic [63:0] e_value_A;
    logic [2:0]  e_stat;
    logic [63:0] f_no_of_valid_instruction;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        m_valid;
    logic [3:0]  m_Ins_Code;
    logic [63:0] m_Value_E;
    logic [63:0] m_Value_M;
    logic [2:0]  m_stat;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_initiator dut (
        .clk                       (clk),
        .reset                     (reset),
        .e_valid                   (e_valid),
        .e_ready                   (e_ready),
        .e_Ins_Code                (e_Ins_Code),
        .e_Ins_fun                 (e_Ins_fun),
        .e_Value_E                 (e_Value_E),
        .e_value_A                 (e_value_A),
        .e_stat                    (e_stat),
        .f_no_of_valid_instruction (f_no_of_valid_instruction),
        .mem_req                   (mem_req),
        .mem_we                    (mem_we),
        .mem_addr                  (mem_addr),
        .mem_wdata                 (mem_wdata),
        .mem_ack                   (mem_ack),
        .mem_rdata                 (mem_rdata),
        .mem_err                   (mem_err),
        .m_valid                   (m_valid),
        .m_Ins_Code                (m_Ins_Code),
        .m_Value_E                 (m_Value_E),
        .m_Value_M                 (m_Value_M),
        .m_stat                    (m_stat),
        .halted                    (halted)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [2:0] st);
        e_valid    = 1'b1;
        e_Ins_Code = ic;
        e_Value_E  = ve;
        e_value_A  = va;
        e_stat     = st;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        e_valid = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        e_Ins_Code = NOP;
        e_Ins_fun  = 4'h0;
        e_Value_E  = '0;
        e_value_A  = '0;
        e_stat     = STAT_AOK;
        mem_rdata  = '0;
        mem_err    = 1'b0;
        f_no_of_valid_instruction = 64'd20;
        #1;
        do_reset();

        chk("rst_mem_req", mem_req, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_m_icode", m_Ins_Code, 1);
        chk("rst_m_stat", m_stat, 0);
        chk("rst_e_ready", e_ready, 1);

        // rmmovq, ack in third REQ cycle
        drive(RMMOV, 64'h10, 64'hABCD, STAT_AOK);
        tick();
        e_valid = 1'b0;
        chk("rm_req1", mem_req, 1);
        chk("rm_addr", mem_addr, 64'h10);
        chk("rm_we", mem_we, 1);
        chk("rm_wdata", mem_wdata, 64'hABCD);
        chk("rm_ready_busy", e_ready, 0);
        tick();
        chk("rm_req2", mem_req, 1);
        tick();
        chk("rm_req3", mem_req, 1);
        chk("rm_addr3", mem_addr, 64'h10);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rm_valid", m_valid, 1);
        chk("rm_req_off", mem_req, 0);
        chk("rm_stat", m_stat, STAT_AOK);
        chk("rm_valM", m_Value_M, 0);
        tick();
        chk("rm_valid_pulse", m_valid, 0);

        // mrmovq at last legal address, ack in first REQ cycle
        drive(MRMOV, 64'd4095, 64'h0, STAT_AOK);
        tick();
        e_valid = 1'b0;
        chk("mr_req", mem_req, 1);
        chk("mr_addr", mem_addr, 64'hFFF);
        chk("mr_we", mem_we, 0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h55;
        tick();
        mem_ack = 1'b0;
        chk("mr_valid", m_valid, 1);
        chk("mr_valM", m_Value_M, 64'h55);
        chk("mr_stat", m_stat, STAT_AOK);
        chk("mr_valE", m_Value_E, 64'd4095);
        chk("mr_icode", m_Ins_Code, MRMOV);
        tick();

        // ret returning to a legal address
        drive(RET, 64'h10, 64'h8, STAT_AOK);
        tick();
        e_valid = 1'b0;
        chk("ret_addr", mem_addr, 64'h8);
        mem_ack   = 1'b1;
        mem_rdata = 64'd12;
        tick();
        mem_ack = 1'b0;
        chk("ret_ok_stat", m_stat, STAT_AOK);
        chk("ret_ok_valM", m_Value_M, 64'd12);
        chk("ret_ok_halted", halted, 0);
        tick();

        // ret returning beyond the program
        drive(RET, 64'h10, 64'h8, STAT_AOK);
        tick();
        e_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'd50;
        tick();
        mem_ack = 1'b0;
        chk("ret_bad_stat", m_stat, STAT_INS);
        chk("ret_bad_halted", halted, 1);
        chk("ret_bad_ready", e_ready, 0);

        do_reset();
        // OPq then mrmovq back-to-back, reset during the read's REQ
        drive(OPQ, 64'h77, 64'h0, STAT_AOK);
        tick();
        chk("op_valid", m_valid, 1);
        chk("op_icode", m_Ins_Code, OPQ);
        chk("op_valE", m_Value_E, 64'h77);
        chk("op_ready_resp", e_ready, 1);
        drive(MRMOV, 64'h20, 64'h0, STAT_AOK);
        tick();
        e_valid = 1'b0;
        chk("b2b_req", mem_req, 1);
        chk("b2b_addr", mem_addr, 64'h20);
        chk("b2b_valid_off", m_valid, 0);
        reset = 1'b1;
        tick();
        chk("midrst_req", mem_req, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_icode", m_Ins_Code, NOP);
        reset   = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_valid", m_valid, 0);
        chk("late_ack_req", mem_req, 0);

        // pushq one word past the end
        drive(PUSH, 64'd4096, 64'h5, STAT_AOK);
        tick();
        chk("push_req", mem_req, 0);
        chk("push_valid", m_valid, 1);
        chk("push_stat", m_stat, STAT_ADR);
        chk("push_halted", halted, 1);
        chk("push_ready", e_ready, 0);
        tick();
        chk("push_valid_once", m_valid, 0);
        chk("push_ready_stuck", e_ready, 0);
        e_valid = 1'b0;

        // status priority: stat[1] over stat[0]
        do_reset();
        drive(MRMOV, 64'h8, 64'h0, 3'b011);
        tick();
        e_valid = 1'b0;
        chk("prio_req", mem_req, 0);
        chk("prio_stat", m_stat, STAT_ADR);

        do_reset();
        drive(HALT, 64'h0, 64'h0, STAT_AOK);
        tick();
        e_valid = 1'b0;
        chk("halt_stat", m_stat, STAT_HLT);
        chk("halt_halted", halted, 1);

        // read with mem_err
        do_reset();
        drive(POP, 64'h0, 64'h30, STAT_AOK);
        tick();
        e_valid = 1'b0;
        chk("pop_addr", mem_addr, 64'h30);
        mem_ack   = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = 64'h99;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        chk("err_stat", m_stat, STAT_ADR);
        chk("err_valM", m_Value_M, 0);

        // no ack ever
        do_reset();
        drive(MRMOV, 64'h40, 64'h0, STAT_AOK);
        tick();
        e_valid = 1'b0;
        cnt = 0;
        while (mem_req && cnt < 40) begin
            cnt++;
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        chk("to_req_cycles", 64'(cnt), 64'd16);
        chk("to_req_off", mem_req, 0);
        chk("to_stat", m_stat, STAT_ADR);
        chk("to_halted", halted, 1);
`else
        chk("noto_req_held", mem_req, 1);
        chk("noto_valid", m_valid, 0);
`endif
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
